// File: rtl/product_accumulator.sv
// Product accumulator: sums 8-bit unsigned products into a wide accumulator over a
// valid/ready handshake and presents the finished sum on a held output handshake.
module product_accumulator #(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned CNT_W    = 4,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [7:0]       in_prod_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             clr_i,
    input  logic             dump_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    typedef enum logic [0:0] {StAccum, StDump} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W:0]     sum_wide;
    logic               carry;
    logic               accept;

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_prod_i};
    assign carry    = sum_wide[ACC_W];
    assign accept   = (state_q == StAccum) && in_valid_i;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clr_i) begin
            // Clear wins over every handshake; a product offered now is dropped.
            state_d     = StAccum;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                        ovf_d   = ovf_q | carry;
                        acc_d   = (SATURATE && carry) ? '1 : sum_wide[ACC_W-1:0];
                    end
                    // Load the output with post-accept values so a same-cycle term counts.
                    if (dump_i || (accept && (count_d == '1))) begin
                        state_d     = StDump;
                        out_sum_d   = acc_d;
                        out_count_d = count_d;
                        out_ovf_d   = ovf_d;
                    end
                end
                StDump: begin
                    if (out_ready_i) begin
                        state_d = StAccum;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (ena_i) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready_o  = (state_q == StAccum);
    assign out_valid_o = (state_q == StDump);
    assign out_sum_o   = out_sum_q;
    assign out_count_o = out_count_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations driven in lockstep and
// compared every cycle against an unbounded-integer reference model.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] in_prod = 8'd0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic       dump = 1'b0;
    logic       out_ready = 1'b0;

    logic        rdy [3];
    logic        vld [3];
    logic        ovf [3];
    logic [3:0]  cnt [3];
    logic [15:0] sum0;
    logic [9:0]  sum1, sum2;
    int          sum [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance accumulator width and saturation mode.
    int aw [3]  = '{16, 10, 10};
    bit sat [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model: true unbounded total plus handshake state.
    int m_total;
    int m_cnt;
    bit m_dump;
    int m_osum [3];
    int m_ocnt;
    bit m_oovf [3];

    always #5 clk = ~clk;

    product_accumulator u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .in_prod_i(in_prod), .in_valid_i(in_valid),
        .in_ready_o(rdy[0]), .clr_i(clr), .dump_i(dump), .out_valid_o(vld[0]),
        .out_ready_i(out_ready), .out_sum_o(sum0), .out_count_o(cnt[0]), .out_ovf_o(ovf[0])
    );

    product_accumulator #(.ACC_W(10), .CNT_W(4), .SATURATE(1'b1)) u_dut10s (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .in_prod_i(in_prod), .in_valid_i(in_valid),
        .in_ready_o(rdy[1]), .clr_i(clr), .dump_i(dump), .out_valid_o(vld[1]),
        .out_ready_i(out_ready), .out_sum_o(sum1), .out_count_o(cnt[1]), .out_ovf_o(ovf[1])
    );

    product_accumulator #(.ACC_W(10), .CNT_W(4), .SATURATE(1'b0)) u_dut10w (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .in_prod_i(in_prod), .in_valid_i(in_valid),
        .in_ready_o(rdy[2]), .clr_i(clr), .dump_i(dump), .out_valid_o(vld[2]),
        .out_ready_i(out_ready), .out_sum_o(sum2), .out_count_o(cnt[2]), .out_ovf_o(ovf[2])
    );

    assign sum[0] = int'(sum0);
    assign sum[1] = int'(sum1);
    assign sum[2] = int'(sum2);

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_val(input int i);
        int lim = 1 << aw[i];
        if (m_total < lim) return m_total;
        return sat[i] ? lim - 1 : m_total % lim;
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
        m_dump  = 1'b0;
        m_ocnt  = 0;
        for (int i = 0; i < 3; i++) begin
            m_osum[i] = 0;
            m_oovf[i] = 1'b0;
        end
    endtask

    // Applies one clock of the handshake rules using the inputs held across the edge.
    task automatic model_tick();
        if (!ena) return;
        if (clr) begin
            model_reset();
        end else if (!m_dump) begin
            if (in_valid) begin
                m_total += int'(in_prod);
                m_cnt++;
            end
            if (dump || m_cnt == 15) begin
                m_dump = 1'b1;
                m_ocnt = m_cnt;
                for (int i = 0; i < 3; i++) begin
                    m_osum[i] = model_val(i);
                    m_oovf[i] = (m_total >= (1 << aw[i]));
                end
            end
        end else if (out_ready) begin
            m_dump  = 1'b0;
            m_total = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), int'(rdy[i]), int'(!m_dump));
            check($sformatf("out_valid[%0d]", i), int'(vld[i]), int'(m_dump));
            check($sformatf("out_sum[%0d]", i), sum[i], m_osum[i]);
            check($sformatf("out_count[%0d]", i), int'(cnt[i]), m_ocnt);
            check($sformatf("out_ovf[%0d]", i), int'(ovf[i]), int'(m_oovf[i]));
        end
    endtask

    task automatic drive(input bit v, input int p, input bit d, input bit c, input bit e,
                         input bit r);
        in_valid  = v;
        in_prod   = 8'(p);
        dump      = d;
        clr       = c;
        ena       = e;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 1, 0);
        #3;
        compare_all();
        rst_n = 1'b1;
        step();

        // 15 x 225 with the consumer stalled: auto-dump, then 5 held cycles.
        for (int k = 0; k < 15; k++) begin
            drive(1, 225, 0, 0, 1, 0);
            step();
        end
        check("auto_sum", sum[0], 3375);
        check("auto_cnt", int'(cnt[0]), 15);
        check("auto_ovf", int'(ovf[0]), 0);
        check("auto_vld", int'(vld[0]), 1);
        for (int k = 0; k < 5; k++) step();
        check("stall_rdy", int'(rdy[0]), 0);
        check("stall_sum", sum[0], 3375);
        drive(0, 0, 0, 0, 1, 1);
        step();
        check("release_rdy", int'(rdy[0]), 1);

        // 3, 7, 12 with dump on the last term, then an empty dump.
        drive(1, 3, 0, 0, 1, 0); step();
        drive(1, 7, 0, 0, 1, 0); step();
        drive(1, 12, 1, 0, 1, 0); step();
        check("dump_sum", sum[0], 22);
        check("dump_cnt", int'(cnt[0]), 3);
        drive(0, 0, 0, 0, 1, 1); step();
        drive(0, 0, 1, 0, 1, 0); step();
        check("empty_vld", int'(vld[0]), 1);
        check("empty_sum", sum[0], 0);
        check("empty_cnt", int'(cnt[0]), 0);
        drive(0, 0, 0, 0, 1, 1); step();

        // 5 x 225 then dump: 1125 in 16 bits, clamps or wraps in 10 bits.
        for (int k = 0; k < 5; k++) begin
            drive(1, 225, 0, 0, 1, 0);
            step();
        end
        drive(0, 0, 1, 0, 1, 0); step();
        check("w16_sum", sum[0], 1125);
        check("sat_sum", sum[1], 1023);
        check("sat_ovf", int'(ovf[1]), 1);
        check("wrap_sum", sum[2], 101);
        check("wrap_ovf", int'(ovf[2]), 1);
        drive(0, 0, 0, 0, 1, 1); step();
        drive(1, 4, 1, 0, 1, 0); step();
        check("sat_next_sum", sum[1], 4);
        check("sat_next_ovf", int'(ovf[1]), 0);
        drive(0, 0, 0, 0, 1, 1); step();

        // clr drops a same-cycle product; clr while presenting drops out_valid.
        drive(1, 100, 0, 0, 1, 0); step();
        drive(1, 50, 0, 1, 1, 0); step();
        drive(0, 0, 1, 0, 1, 0); step();
        check("clr_sum", sum[0], 0);
        check("clr_cnt", int'(cnt[0]), 0);
        drive(0, 0, 0, 1, 1, 0); step();
        check("clr_vld", int'(vld[0]), 0);

        // Freeze with ena low, then asynchronous reset mid-cycle.
        drive(1, 9, 0, 0, 1, 0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 9, 1, 0, 0, 1);
            step();
        end
        check("frozen_rdy", int'(rdy[0]), 1);
        drive(1, 9, 1, 0, 1, 0); step();
        check("unfreeze_sum", sum[0], 18);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_rdy", int'(rdy[0]), 1);
        check("arst_vld", int'(vld[0]), 0);
        #2;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0);
        step();

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 225)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier's 8-bit product bus.
- Accepts one product per cycle over a valid/ready handshake and sums it into a wide accumulator. Also counts accepted terms and flags overflow.
- Presents the finished sum on a held output handshake when a dump is requested or the term counter fills.
- Sits between the multiplier output and the tile's output muxing, turning the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- ACC_W, 16, accumulator and output sum width in bits. Legal range 9 to 24.
- CNT_W, 4, term counter width. An auto-dump fires after 2^CNT_W-1 accepted terms.
- SATURATE, 1. 1 = clamp the sum at all-ones on overflow; 0 = wrap modulo 2^ACC_W. The overflow flag is set in both modes.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  clock enable. Low freezes all state and outputs.
- in_prod  in  8  unsigned product from the multiplier.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block can accept a product this cycle.
- clr  in  1  synchronous clear of accumulator, count and overflow flag.
- dump  in  1  single-cycle request to present the current sum.
- out_valid  out  1  out_sum / out_count / out_ovf are valid.
- out_ready  in  1  consumer accepts the output.
- out_sum  out  ACC_W  accumulated sum.
- out_count  out  CNT_W  number of terms in out_sum.
- out_ovf  out  1  sticky overflow flag for this sum.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: acc=0, count=0, ovf=0, state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- All updates occur only on rising clk with ena=1. With ena=0, registers hold and outputs are unchanged.

State ACCUM:
- in_ready=1, out_valid=0.
- Accept condition: in_valid&in_ready. On accept:
  - acc <= acc + zero-extended in_prod.
  - count <= count+1.
- Overflow: if the add carries out of ACC_W bits, ovf <= 1.
  - SATURATE=1: acc <= all-ones. Further adds stay at all-ones.
  - SATURATE=0: the sum wraps modulo 2^ACC_W.
- Transition to DUMP when either:
  - dump=1; or
  - the accept brings count to 2^CNT_W-1.
- On transition, out_sum/out_count/out_ovf are loaded with the post-accept values. A product accepted in the same cycle as dump is included.
- dump with no terms (count=0) is legal and yields sum=0, count=0.
- Latency: the output registers and out_valid are visible the cycle after the last accepted term or the dump cycle.

State DUMP:
- out_valid=1, in_ready=0. Outputs are held stable until out_ready=1.
- dump is ignored while in DUMP.
- On out_valid&out_ready:
  - acc, count and ovf reset to 0.
  - State returns to ACCUM; in_ready=1 from the next cycle.
- There is no same-cycle restart: back-to-back sums have a minimum one-cycle bubble on the input.

clr:
- Has priority over accept, dump and output handshake in any state.
- Clears acc, count, ovf, out_valid, out_sum, out_count and out_ovf, and forces ACCUM.
- A product presented in the same cycle as clr is dropped.

Reset mid-operation:
- Asynchronous return to reset values immediately. Any pending output is lost.

Arithmetic:
- Unsigned throughout.
- Max input is 225, so ACC_W=16 cannot overflow within 15 terms. Overflow is reachable only with a smaller ACC_W or SATURATE tests.

Test Plan:
- Reset, then feed 15 x in_prod=225 back-to-back with out_ready=0 -> auto dump. out_valid=1 with out_sum=3375, out_count=15, out_ovf=0. in_ready=0 and outputs held for 5 stall cycles. After out_ready=1, in_ready=1 the cycle after and acc=0.
- Feed 3,7,12, with dump asserted in the same cycle as 12 -> out_sum=22, out_count=3. Then dump with no input -> out_sum=0, out_count=0.
- ACC_W=10, SATURATE=1: feed 5 x 225 then dump -> out_sum=1023, out_ovf=1. Next sum feeds 4 -> out_sum=4, out_ovf=0.
- ACC_W=10, SATURATE=0: feed 5 x 225 then dump -> out_sum=101 (1125 mod 1024), out_ovf=1.
- Accumulate 100, then clr in the same cycle as in_valid with 50, then dump -> out_sum=0, out_count=0. Separately, clr while out_valid=1 drops out_valid next cycle.
- Accumulate 9, then hold ena=0 for 4 cycles with in_valid=1 -> no accept, state frozen. Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 before the next edge and in_ready=1.
